// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a little-endian 8N1 byte stream while prog_en is
// high, packs every four bytes into a 32-bit word and writes it through the
// memory back-door port at an incrementing word address. The core is held in
// reset while loading.
// Optional build macro: UART_PROG_LOADER_FLUSH_EN -- when defined, a partial
// word left over at the prog_en fall is written out zero-filled.
//
// Handshake: there is none on the write side. write is a one-cycle strobe,
// and wraddrin/wrdatain are valid in that cycle and hold until the next one.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              uart_rx,
    input  logic              prog_en,
    output logic              write,
    output logic [ADDR_W-1:0] wraddrin,
    output logic [31:0]       wrdatain,
    output logic              cpu_resetn,
    output logic [ADDR_W-1:0] word_cnt,
    output logic              frame_err
);

    localparam int                HALF      = CLKS_PER_BIT / 2;
    localparam logic [15:0]       HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0]       BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Synchronisers and edge-detect history
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic pe_meta_q, pe_sync_q, pe_prev_q;

    // Receiver state
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_vld_q, byte_vld_d;
    logic        ferr_set;

    // Word assembly and outputs
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       stage_q, stage_d;
    logic [31:0]       word_next;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [31:0]       wrdata_q, wrdata_d;
    logic              ferr_q, ferr_d;
    logic              cpu_rstn_q, cpu_rstn_d;

    logic pe_rise, pe_fall, rx_fall;

    assign pe_rise = pe_sync_q & ~pe_prev_q;
    assign pe_fall = ~pe_sync_q & pe_prev_q;
    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            pe_meta_q <= 1'b0;
            pe_sync_q <= 1'b0;
            pe_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            pe_meta_q <= prog_en;
            pe_sync_q <= pe_meta_q;
            pe_prev_q <= pe_sync_q;
        end
    end

    // Receiver state register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first. An IDLE entered with
    // rx still low (bad stop bit) needs rx to go high before rx_fall can fire.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        ferr_set   = 1'b0;
        if (!pe_sync_q) begin
            state_d   = ST_IDLE;
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 16'd0;
                    if (rx_fall) state_d = ST_START;
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d     = 16'd0;
                        bit_idx_d = 3'd0;
                        state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = 16'd0;
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_d = ST_STOP;
                        else bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                        if (rx_sync_q) byte_vld_d = 1'b1;
                        else ferr_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Incoming byte merged into its lane; lanes above byte_cnt stay zero
    assign word_next = stage_q | ({24'd0, shift_q} << {byte_cnt_q, 3'b000});

    // Word assembly, address counter, flush and core-reset control
    always_comb begin
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        stage_d    = stage_q;
        write_d    = 1'b0;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;
        ferr_d     = ferr_q | ferr_set;
        if (pe_rise) begin
            addr_d     = '0;
            byte_cnt_d = 2'd0;
            stage_d    = 32'd0;
            ferr_d     = 1'b0;
        end else if (pe_fall) begin
`ifdef UART_PROG_LOADER_FLUSH_EN
            if (byte_cnt_q != 2'd0) begin
                write_d  = 1'b1;
                wraddr_d = addr_q;
                wrdata_d = stage_q;
                addr_d   = addr_q + ADDR_ONE;
            end
`endif
            byte_cnt_d = 2'd0;
            stage_d    = 32'd0;
        end else if (byte_vld_q) begin
            if (byte_cnt_q == 2'd3) begin
                write_d    = 1'b1;
                wraddr_d   = addr_q;
                wrdata_d   = word_next;
                addr_d     = addr_q + ADDR_ONE;
                byte_cnt_d = 2'd0;
                stage_d    = 32'd0;
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                stage_d    = word_next;
            end
        end
        // pe_prev_q is still high in the cycle a flush is requested, so the
        // release lands the cycle after the flush write (two after the fall).
        cpu_rstn_d = ~(pe_sync_q | pe_prev_q);
    end

    // Word assembly and output registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q     <= '0;
            byte_cnt_q <= 2'd0;
            stage_q    <= 32'd0;
            write_q    <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= 32'd0;
            ferr_q     <= 1'b0;
            cpu_rstn_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            stage_q    <= stage_d;
            write_q    <= write_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
            ferr_q     <= ferr_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    assign write      = write_q;
    assign wraddrin   = wraddr_q;
    assign wrdatain   = wrdata_q;
    assign word_cnt   = addr_q;   // words written since the rise == next address
    assign frame_err  = ferr_q;
    assign cpu_resetn = cpu_rstn_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader with CLKS_PER_BIT = 8. Honours the build macro
// UART_PROG_LOADER_FLUSH_EN when computing expected flush behaviour.
module tb_uart_prog_loader;

    localparam int CLKS   = 8;
    localparam int ADDR_W = 16;
`ifdef UART_PROG_LOADER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              uart_rx;
    logic              prog_en;
    logic              write;
    logic [ADDR_W-1:0] wraddrin;
    logic [31:0]       wrdatain;
    logic              cpu_resetn;
    logic [ADDR_W-1:0] word_cnt;
    logic              frame_err;

    uart_prog_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(ADDR_W)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .uart_rx    (uart_rx),
        .prog_en    (prog_en),
        .write      (write),
        .wraddrin   (wraddrin),
        .wrdatain   (wrdatain),
        .cpu_resetn (cpu_resetn),
        .word_cnt   (word_cnt),
        .frame_err  (frame_err)
    );

    // Clock
    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;

    // Expected writes: {addr[15:0], data[31:0]}
    logic [47:0] exp_q[$];

    // Model of the loader at the byte/word level
    logic [15:0] m_addr = 16'd0;
    logic [7:0]  m_part[4];
    int          m_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_rise();
        m_addr = 16'd0;
        m_n    = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_part[m_n] = b;
        m_n++;
        if (m_n == 4) begin
            exp_q.push_back({m_addr, m_part[3], m_part[2], m_part[1], m_part[0]});
            m_addr = m_addr + 16'd1;
            m_n    = 0;
        end
    endtask

    task automatic model_fall();
        logic [31:0] w;
        if (FLUSH && m_n != 0) begin
            w = 32'd0;
            for (int i = 0; i < m_n; i++) w[8*i +: 8] = m_part[i];
            exp_q.push_back({m_addr, w});
            m_addr = m_addr + 16'd1;
        end
        m_n = 0;
    endtask

    // Driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge hclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(CLKS);
        end
        uart_rx = stop_bit;
        cycles(CLKS);
        uart_rx = 1'b1;
        cycles(2 * CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1);
    endtask

    task automatic prog_high();
        model_rise();
        prog_en = 1'b1;
        cycles(6);
    endtask

    task automatic prog_low();
        int n;
        model_fall();
        prog_en = 1'b0;
        n = 0;
        while (!cpu_resetn && n < 12) begin
            @(negedge hclk);
            n++;
        end
        check("cpu_release_cycles", n, 4);
        cycles(4);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_write"}, write, 0);
        check({tag, "_wraddrin"}, wraddrin, 0);
        check({tag, "_wrdatain"}, wrdatain, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_cpu_resetn"}, cpu_resetn, 0);
    endtask

    // Scoreboard: every write strobe is matched against the model queue
    logic        prev_wr = 1'b0;
    logic [15:0] held_addr = 16'd0;
    logic [31:0] held_data = 32'd0;
    always @(negedge hclk) begin
        logic [47:0] e;
        if (!hresetn) begin
            prev_wr   = 1'b0;
            held_addr = 16'd0;
            held_data = 32'd0;
        end else begin
            if (write) begin
                wr_seen++;
                check("write_gap_prev_cycle", prev_wr, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                             wraddrin, wrdatain);
                    held_addr = wraddrin;
                    held_data = wrdatain;
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", wraddrin, e[47:32]);
                    check("write_data", wrdatain, e[31:0]);
                    held_addr = e[47:32];
                    held_data = e[31:0];
                end
            end else begin
                check("hold_addr", wraddrin, held_addr);
                check("hold_data", wrdatain, held_data);
            end
            prev_wr = write;
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Directed scenarios
    initial begin
        int base;
        logic [31:0] exp_data;
        logic [31:0] exp_wc;

        hresetn = 1'b0;
        uart_rx = 1'b1;
        prog_en = 1'b0;
        cycles(3);
        check_reset_values("rst");
        hresetn = 1'b1;
        cycles(4);

        // One word 0x12345678 at address 0
        prog_high();
        check("s1_cpu_held", cpu_resetn, 0);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("s1_writes", wr_seen, 1);
        check("s1_wraddrin", wraddrin, 16'h0000);
        check("s1_wrdatain", wrdatain, 32'h12345678);
        check("s1_word_cnt", word_cnt, 1);
        check("s1_cpu_resetn", cpu_resetn, 0);
        prog_low();

        // Two words, then release the core
        prog_high();
        check("s2_word_cnt_cleared", word_cnt, 0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("s2_writes", wr_seen, 3);
        check("s2_wraddrin", wraddrin, 16'h0001);
        check("s2_wrdatain", wrdatain, 32'h08070605);
        prog_low();
        check("s2_cpu_resetn", cpu_resetn, 1);
        check("s2_word_cnt", word_cnt, 2);

        // Framing error is dropped and sticky; cleared by the next rise
        prog_high();
        send_frame(8'hAA, 1'b0);
        check("s3_frame_err_set", frame_err, 1);
        check("s3_word_cnt_after_bad", word_cnt, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("s3_writes", wr_seen, 4);
        check("s3_wraddrin", wraddrin, 16'h0000);
        check("s3_wrdatain", wrdatain, 32'h44332211);
        check("s3_frame_err_sticky", frame_err, 1);
        prog_low();
        prog_high();
        check("s3_frame_err_cleared", frame_err, 0);
        check("s3_word_cnt_cleared", word_cnt, 0);

        // Short low glitch: no byte; following bytes still word-aligned
        uart_rx = 1'b0;
        cycles(3);
        uart_rx = 1'b1;
        cycles(5 * CLKS);
        check("s4_frame_err", frame_err, 0);
        check("s4_no_write", wr_seen, 4);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        check("s4_wrdatain", wrdatain, 32'hC3C2C1C0);
        check("s4_word_cnt", word_cnt, 1);
        prog_low();

        // Partial word at the fall
        prog_high();
        base = wr_seen;
        send_byte(8'hDE); send_byte(8'hAD);
        prog_low();
        exp_data = FLUSH ? 32'h0000ADDE : 32'hC3C2C1C0;
        exp_wc   = FLUSH ? 32'd1 : 32'd0;
        check("s5_writes", wr_seen - base, exp_wc);
        check("s5_wrdatain", wrdatain, exp_data);
        check("s5_wraddrin", wraddrin, 16'h0000);
        check("s5_word_cnt", word_cnt, exp_wc);
        check("s5_cpu_resetn", cpu_resetn, 1);

        // Address wrap from 0xFFFF
        prog_high();
        force dut.addr_q = 16'hFFFF;
        cycles(2);
        release dut.addr_q;
        cycles(1);
        m_addr = 16'hFFFF;
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        check("s6_wraddrin_top", wraddrin, 16'hFFFF);
        check("s6_wrdatain_top", wrdatain, 32'hA3A2A1A0);
        check("s6_word_cnt_wrapped", word_cnt, 0);
        send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        check("s6_wraddrin_wrap", wraddrin, 16'h0000);
        check("s6_wrdatain_wrap", wrdatain, 32'hB3B2B1B0);
        check("s6_word_cnt", word_cnt, 1);

        // Reset asserted in the middle of a byte
        base = wr_seen;
        fork
            send_frame(8'h55, 1'b1);
            begin
                cycles(30);
                @(posedge hclk);
                #2;
                hresetn = 1'b0;
                #1;
                check_reset_values("s7_async");
                cycles(2);
                prog_en = 1'b0;
                check_reset_values("s7_held");
                cycles(2);
                hresetn = 1'b1;
            end
        join
        cycles(6 * CLKS);
        check("s7_no_write", wr_seen - base, 0);
        check("s7_word_cnt", word_cnt, 0);
        check("s7_wrdatain", wrdatain, 0);
        check("s7_frame_err", frame_err, 0);
        check("s7_cpu_resetn", cpu_resetn, 1);
        check("s7_pending_writes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART program loader sitting directly upstream of the AHB slave memory interface; it drives that interface's `write`, `wraddrin` and `wrdatain` back-door port.
- Receives a raw little-endian byte stream over 8N1 UART while `prog_en` is high.
- Packs every 4 bytes into one 32-bit word and issues a single-cycle write at an incrementing word address.
- Holds the CPU in reset until programming completes.

Parameters:
- CLKS_PER_BIT, 434, hclk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- ADDR_W, 16, word-address width; must match `wraddrin`.

Ports:
- hclk  in  1  system clock; all logic on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input, idle high, asynchronous to hclk.
- prog_en  in  1  programming-mode request (switch/debugger level).
- write  out  1  one-cycle write strobe to the memory interface.
- wraddrin  out  ADDR_W  word address for `write`.
- wrdatain  out  32  write data for `write`.
- cpu_resetn  out  1  active-low reset to the core; low while loading.
- word_cnt  out  ADDR_W  number of words written since last `prog_en` rise.
- frame_err  out  1  sticky flag: a stop bit sampled low; cleared on `prog_en` rise.

Behaviour:
- Reset values:
  - `write` = 0, `wraddrin` = 0, `wrdatain` = 0, `word_cnt` = 0, `frame_err` = 0.
  - `cpu_resetn` = 0.
  - All internal state cleared; RX FSM in IDLE.
- Input synchronisation: `uart_rx` and `prog_en` each pass a 2-flop synchroniser. The `uart_rx` synchroniser resets to 1. All behaviour below refers to the synchronised signals.
- `prog_en` rise (registered edge detect): clear address counter, `word_cnt`, byte counter and `frame_err`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: on a 1→0 transition of synchronised rx while `prog_en` = 1.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If low → DATA with bit counter 0. If high → IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT cycles; shift LSB first; after bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - High: byte valid for one cycle; → IDLE.
    - Low: byte dropped, `frame_err` = 1; → IDLE, which then waits for rx to return high before accepting a new start.
  - `prog_en` = 0 in any state forces IDLE next cycle; a partial byte is discarded.
- Word assembly:
  - byte_cnt runs 0..3; byte k lands in `wrdatain` staging bits [8k+7:8k] (byte lane k = lowest address first).
  - On the 4th valid byte, the cycle after the byte is valid:
    - `write` = 1 for exactly one cycle.
    - `wraddrin` = current address; `wrdatain` = packed word.
    - Address and `word_cnt` then increment.
  - `wraddrin` and `wrdatain` hold their values until the next write.
  - Address wraps at 2^ADDR_W−1 → 0 with no flag; `word_cnt` wraps identically.
  - Back-to-back words are at least 10·CLKS_PER_BIT cycles apart, so `write` is never asserted on consecutive cycles.
- `prog_en` fall:
  - Any partial word (byte_cnt 1..3) is handled per the optional feature.
  - byte_cnt is then cleared.
  - `cpu_resetn` rises 2 cycles after the synchronised fall, after any flush write has completed.
- `cpu_resetn` = 0 whenever synchronised `prog_en` = 1 or a flush is pending; otherwise 1. It is registered (glitch-free).
- `hresetn` asserted mid-transfer: everything returns to reset values immediately; no write is issued.

Optional Feature:
- Macro: `UART_PROG_LOADER_FLUSH_EN`.
- Defined: on `prog_en` fall with byte_cnt ≠ 0, issue one flush write with unreceived lanes zero-filled, at the current address. Address and `word_cnt` increment. `cpu_resetn` releases the cycle after the flush write.
- Undefined: partial bytes are silently discarded; no write is issued; address is unchanged.

Test Plan (bench uses CLKS_PER_BIT = 8):
- Reset, `prog_en` = 1, send bytes 0x78 0x56 0x34 0x12 → one `write` pulse, `wraddrin` = 0x0000, `wrdatain` = 0x12345678; `word_cnt` = 1; `cpu_resetn` = 0.
- Send 8 bytes 0x01..0x08 → writes 0x04030201 @0x0000 and 0x08070605 @0x0001; drop `prog_en` → `cpu_resetn` = 1 within 4 cycles; `word_cnt` = 2.
- Send 0xAA with stop bit forced low, then 0x11 0x22 0x33 0x44 → `frame_err` = 1; single write 0x44332211 @0x0000; next `prog_en` rise clears `frame_err`.
- 3-cycle low glitch on rx in IDLE → no byte, no `frame_err`, no write.
- Send 0xDE 0xAD, then drop `prog_en` → with macro: write 0x0000ADDE @0x0000; without: no write. In both cases `cpu_resetn` = 1 afterwards.
- Preload address to 0xFFFF (send 0x10000 words, or force in sim), send 4 bytes → write @0xFFFF; next word @0x0000. Assert `hresetn` mid-byte → all outputs at reset values; no write.
